// File: rtl/pchb_adder_driver.sv
// Clocked front-end for the asynchronous PCHB 4-bit adder stage.
// Operand pairs are queued in a small FIFO and presented to the adder
// under bundled-data rules with a four-phase req/ack handshake. The
// returned sum is captured into a single-entry valid/ready result slot.
// A per-phase watchdog pulses the adder reset and posts an error result
// when the adder stops responding.
//
// state      | meaning
// S_IDLE     | no operation in flight, en low, waiting for FIFO data
// S_SETUP    | operands driven, one cycle of data setup before req rises
// S_REQ_HI   | req high, waiting for synchronized ack and a free result slot
// S_REQ_LO   | req low, waiting for synchronized ack to return to zero
// S_RECOVER  | adder held in reset for two cycles after a watchdog expiry

module pchb_adder_driver #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [3:0]               i_in_a,
    input  logic [3:0]               i_in_b,
    output logic                     o_req,
    input  logic                     i_ack,
    output logic [3:0]               o_a_out,
    output logic [3:0]               o_b_out,
    output logic                     o_en,
    output logic                     o_adder_rst,
    input  logic [3:0]               i_sum_in,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [3:0]               o_res_sum,
    output logic                     o_res_err,
    output logic                     o_timeout_err,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Down-counter load value: terminal count is reached after TIMEOUT
    // cycles spent in a handshake wait state.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_REQ_HI  = 3'd2,
        S_REQ_LO  = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                r_state;

    logic [7:0]            r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [SYNC_STAGES-1:0] r_ack_sync;

    logic                  r_req;
    logic                  r_en;
    logic                  r_adder_rst;
    logic [3:0]            r_a_out;
    logic [3:0]            r_b_out;
    logic                  r_res_valid;
    logic [3:0]            r_res_sum;
    logic                  r_res_err;
    logic                  r_timeout_err;
    logic                  r_err_pend;
    logic [7:0]            r_tmo_cnt;
    logic                  r_rec_cnt;

    logic                  w_ack_s;
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_head;
    logic                  w_slot_free;
    logic                  w_hs_done;
    logic                  w_tmo_tc;

    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign o_in_ready  = (r_count < FULL_CNT);
    assign w_push      = i_in_valid && o_in_ready;
    // The FSM takes a new operand pair only from IDLE or when closing a
    // handshake in REQ_LO; both paths share this single pop condition.
    assign w_pop       = (r_count != '0) &&
                         ((r_state == S_IDLE) || ((r_state == S_REQ_LO) && !w_ack_s));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_slot_free = !r_res_valid || i_res_ready;
    // A pending timeout error result must leave the slot before any newer sum.
    assign w_hs_done   = w_ack_s && w_slot_free && !r_err_pend;
    assign w_tmo_tc    = (r_tmo_cnt == 8'd0);

    // Bring the asynchronous adder acknowledge into the clock domain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    // Operand storage; contents are don't-care until written, pointers guard reads.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_a, i_in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Handshake sequencer with registered adder controls and result slot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_en          <= 1'b0;
            r_adder_rst   <= 1'b0;
            r_a_out       <= '0;
            r_b_out       <= '0;
            r_res_valid   <= 1'b0;
            r_res_sum     <= '0;
            r_res_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_pend    <= 1'b0;
            r_tmo_cnt     <= '0;
            r_rec_cnt     <= 1'b0;
        end else begin
            if (r_res_valid && i_res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (r_err_pend && w_slot_free) begin
                r_res_valid <= 1'b1;
                r_res_err   <= 1'b1;
                r_res_sum   <= '0;
                r_err_pend  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_a_out <= w_head[7:4];
                        r_b_out <= w_head[3:0];
                        r_en    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    r_req     <= 1'b1;
                    r_tmo_cnt <= TMO_LOAD;
                    r_state   <= S_REQ_HI;
                end

                S_REQ_HI: begin
                    if (w_hs_done) begin
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b0;
                        r_res_sum   <= i_sum_in;
                        r_req       <= 1'b0;
                        r_tmo_cnt   <= TMO_LOAD;
                        r_state     <= S_REQ_LO;
                    end else if (w_tmo_tc) begin
                        r_req         <= 1'b0;
                        r_en          <= 1'b0;
                        r_adder_rst   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_rec_cnt     <= 1'b0;
                        r_state       <= S_RECOVER;
                        // If an older error result is draining this cycle, this
                        // one is queued behind it rather than overwriting it.
                        if (w_slot_free && !r_err_pend) begin
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_sum   <= '0;
                        end else begin
                            r_err_pend  <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 8'd1;
                    end
                end

                S_REQ_LO: begin
                    if (!w_ack_s) begin
                        if (w_pop) begin
                            r_a_out <= w_head[7:4];
                            r_b_out <= w_head[3:0];
                            r_state <= S_SETUP;
                        end else begin
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo_tc) begin
                        r_en          <= 1'b0;
                        r_adder_rst   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_rec_cnt     <= 1'b0;
                        r_state       <= S_RECOVER;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 8'd1;
                    end
                end

                S_RECOVER: begin
                    if (r_rec_cnt) begin
                        r_adder_rst <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_rec_cnt <= 1'b1;
                    end
                end

                default: begin
                    r_req       <= 1'b0;
                    r_en        <= 1'b0;
                    r_adder_rst <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req         = r_req;
    assign o_en          = r_en;
    assign o_adder_rst   = r_adder_rst;
    assign o_a_out       = r_a_out;
    assign o_b_out       = r_b_out;
    assign o_res_valid   = r_res_valid;
    assign o_res_sum     = r_res_sum;
    assign o_res_err     = r_res_err;
    assign o_timeout_err = r_timeout_err;
    assign o_count       = r_count;

endmodule

// File: tb/tb_pchb_adder_driver.sv
// Bench for pchb_adder_driver: a behavioural adder with combinational ack,
// a scoreboard of expected results fed at push time, and a monitor that
// pops and compares on every result handover.

module tb_pchb_adder_driver;

    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 255;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              in_a;
    logic [3:0]              in_b;
    logic                    req;
    logic                    ack;
    logic [3:0]              a_out;
    logic [3:0]              b_out;
    logic                    en;
    logic                    adder_rst;
    logic [3:0]              sum_in;
    logic                    res_valid;
    logic                    res_ready;
    logic [3:0]              res_sum;
    logic                    res_err;
    logic                    timeout_err;
    logic [$clog2(DEPTH):0]  count;

    logic                    ack_en;

    pchb_adder_driver #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_a        (in_a),
        .i_in_b        (in_b),
        .o_req         (req),
        .i_ack         (ack),
        .o_a_out       (a_out),
        .o_b_out       (b_out),
        .o_en          (en),
        .o_adder_rst   (adder_rst),
        .i_sum_in      (sum_in),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_sum     (res_sum),
        .o_res_err     (res_err),
        .o_timeout_err (timeout_err),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    // Adder stand-in: ack mirrors req unless the adder is "stuck"; sum wraps at 4 bits.
    assign ack    = req & ack_en;
    assign sum_in = a_out + b_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [4:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every handover must match the oldest expected result.
    always @(negedge clk) begin
        logic [4:0] e;
        if (reset_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: actual sum=%0d err=%0d required=no result", res_sum, res_err);
            end else begin
                e = exp_q.pop_front();
                chk("res_sum", int'(res_sum), int'(e[3:0]));
                chk("res_err", int'(res_err), int'(e[4]));
            end
        end
    end

    // Event tracker: edge times of the adder interface and bundled-data checks.
    logic       prev_req = 1'b0;
    logic       prev_en  = 1'b0;
    logic       prev_rv  = 1'b0;
    logic [7:0] hs_ab    = '0;
    int         req_rise_q [$];
    int         last_req_rise = 0;
    int         last_req_fall = 0;
    int         en_rise_cyc   = 0;
    int         en_fall_cyc   = 0;
    int         rv_rise_cyc   = 0;
    int         arst_cnt      = 0;
    int         rdy_low_cnt   = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (req && !prev_req) begin
                req_rise_q.push_back(cyc);
                last_req_rise = cyc;
                hs_ab = {a_out, b_out};
            end else if (req) begin
                chk("req_data_stable", int'({a_out, b_out}), int'(hs_ab));
            end
            if (req) chk("en_during_req", int'(en), 1);
            if (!req && prev_req) last_req_fall = cyc;
            if (en && !prev_en) en_rise_cyc = cyc;
            if (!en && prev_en) en_fall_cyc = cyc;
            if (res_valid && !prev_rv) rv_rise_cyc = cyc;
            if (adder_rst) arst_cnt++;
            if (!in_ready) rdy_low_cnt++;
        end
        prev_req = req;
        prev_en  = en;
        prev_rv  = res_valid;
    end

    // Offer one pair; queue its expected result once the DUT accepts it.
    task automatic push_op(input logic [3:0] a, input logic [3:0] b,
                           input logic exp_err, output int pc);
        int w;
        int s;
        w = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && w < 2000) begin
            w++;
            @(negedge clk);
        end
        chk("push_accepted", int'(in_ready), 1);
        if (in_ready) begin
            s = (int'(a) + int'(b)) % 16;
            if (exp_err) exp_q.push_back(5'b10000);
            else         exp_q.push_back({1'b0, s[3:0]});
        end
        @(posedge clk);
        #1;
        pc       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int max);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || en || res_valid || adder_rst) && w < max) begin
            @(negedge clk);
            w++;
        end
        chk(nm, exp_q.size(), 0);
        chk({nm, "_count"}, int'(count), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int tmp;
        int w;
        int g;
        int s1;
        int s2;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic [3:0] rd;
        logic rand_done;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        ack_en    = 1'b1;
        res_ready = 1'b1;
        rand_done = 1'b0;

        // Reset state
        #12;
        chk("rst_req",         int'(req), 0);
        chk("rst_en",          int'(en), 0);
        chk("rst_adder_rst",   int'(adder_rst), 0);
        chk("rst_a_out",       int'(a_out), 0);
        chk("rst_b_out",       int'(b_out), 0);
        chk("rst_res_valid",   int'(res_valid), 0);
        chk("rst_res_sum",     int'(res_sum), 0);
        chk("rst_res_err",     int'(res_err), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_count",       int'(count), 0);
        chk("rst_in_ready",    int'(in_ready), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single op, minimum latency
        push_op(4'd3, 4'd5, 1'b0, e0);
        wait_drain("single_drain", 100);
        chk("single_en_rise",   en_rise_cyc - e0, 1);
        chk("single_req_rise",  last_req_rise - e0, 2);
        chk("single_res_valid", rv_rise_cyc - e0, 5);
        chk("single_req_fall",  last_req_fall - e0, 5);
        chk("single_en_fall",   en_fall_cyc - e0, 8);

        // Wrap and back-to-back throughput
        req_rise_q.delete();
        rdy_low_cnt = 0;
        push_op(4'd9,  4'd9, 1'b0, e0);
        push_op(4'd15, 4'd1, 1'b0, tmp);
        push_op(4'd7,  4'd7, 1'b0, tmp);
        wait_drain("wrap_drain", 200);
        chk("wrap_req_count", req_rise_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("wrap_req_rise", (req_rise_q.size() > i) ? req_rise_q[i] - e0 : -1, 2 + 7 * i);
        end
        chk("wrap_in_ready_low", rdy_low_cnt, 0);

        // Full FIFO with the adder stuck
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
            if (i == 0) e0 = tmp;
        end
        chk("full_first_pop", en_rise_cyc - e0, 1);
        @(negedge clk);
        chk("full_count",    int'(count), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        fork
            push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
            begin
                repeat (3) @(negedge clk);
                chk("full_refused_count", int'(count), DEPTH);
                chk("full_refused_ready", int'(in_ready), 0);
                ack_en = 1'b1;
            end
        join
        wait_drain("full_drain", 600);

        // Backpressure on the result port
        res_ready = 1'b0;
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rc = 4'($urandom_range(0, 15));
        rd = 4'($urandom_range(0, 15));
        s1 = (int'(ra) + int'(rb)) % 16;
        s2 = (int'(rc) + int'(rd)) % 16;
        push_op(ra, rb, 1'b0, tmp);
        push_op(rc, rd, 1'b0, tmp);
        w = 0;
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_first_valid", int'(res_valid), 1);
        repeat (12) @(negedge clk);
        chk("bp_req_held",   int'(req), 1);
        chk("bp_sum_held",   int'(res_sum), s1);
        chk("bp_valid_held", int'(res_valid), 1);
        chk("bp_count",      int'(count), 0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", int'(res_valid), 1);
        chk("bp_second_sum",   int'(res_sum), s2);
        chk("bp_second_req",   int'(req), 0);
        res_ready = 1'b1;
        wait_drain("bp_drain", 100);

        // Handshake timeout
        ack_en   = 1'b0;
        arst_cnt = 0;
        push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, tmp);
        wait_drain("tmo_drain", 600);
        chk("tmo_req_high_cycles", last_req_fall - last_req_rise, TIMEOUT);
        chk("tmo_adder_rst_cycles", arst_cnt, 2);
        chk("tmo_placeholder_time", rv_rise_cyc - last_req_fall, 0);
        chk("tmo_err_set", int'(timeout_err), 1);
        ack_en = 1'b1;
        push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
        wait_drain("tmo_after_drain", 100);
        chk("tmo_err_sticky", int'(timeout_err), 1);

        // Asynchronous reset while req is high
        push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
        push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
        w = 0;
        while (!req && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("arst_reached_req", int'(req), 1);
        chk("arst_pre_count", int'(count), 1);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_req",         int'(req), 0);
        chk("arst_en",          int'(en), 0);
        chk("arst_res_valid",   int'(res_valid), 0);
        chk("arst_count",       int'(count), 0);
        chk("arst_timeout_err", int'(timeout_err), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
        wait_drain("arst_after_drain", 100);

        // Randomized traffic with random result backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    g = int'($urandom_range(0, 3));
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    push_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, tmp);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_drain("rand_drain", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
